serial_adder: RTL and testbench

Bit-serial ripple adder that adds two WIDTH-bit operands plus a carry-in, one bit per clock, LSB first. It is the addition counterpart of the team's combinational four-bit subtractor: it shares the same operand naming (a, b, c) and the same 4-bit default width, but it is sequential, with a start/busy/done handshake. It serves as the area-minimal arithmetic unit in designs that can tolerate WIDTH-cycle latency.

---
 rtl/serial_adder.sv | 122 ++++++++++++
 tb/tb_serial_adder.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: {co,s} = a + b + c, one bit per clock, LSB first.
// A start accepted in IDLE loads the operands; WIDTH edges later s/co update
// and done pulses for one cycle. s/co hold the last completed result.
module serial_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             busy,
    output logic             done
);

    localparam int            CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] ra_q, ra_d;
    logic [WIDTH-1:0] rb_q, rb_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             cy_q, cy_d;
    logic             co_q, co_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Full-adder slice operating on the current LSBs.
    logic             sum_bit;
    logic             cy_nxt;
    logic [WIDTH-1:0] acc_shift;

    assign sum_bit   = ra_q[0] ^ rb_q[0] ^ cy_q;
    assign cy_nxt    = (ra_q[0] & rb_q[0]) | (cy_q & (ra_q[0] ^ rb_q[0]));
    // Shift right with the new sum bit entering at the MSB.
    assign acc_shift = WIDTH'({sum_bit, acc_q} >> 1);

    // Next-state and datapath: load on accept, shift while in SHIFT.
    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        acc_d   = acc_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        cy_d    = cy_q;
        co_d    = co_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    ra_d    = a;
                    rb_d    = b;
                    cy_d    = c;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                ra_d  = ra_q >> 1;
                rb_d  = rb_q >> 1;
                cy_d  = cy_nxt;
                acc_d = acc_shift;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    s_d     = acc_shift;
                    co_d    = cy_nxt;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            acc_q   <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            cy_q    <= 1'b0;
            co_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            acc_q   <= acc_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            cy_q    <= cy_d;
            co_q    <= co_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign s    = s_q;
    assign co   = co_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=4): reset, basic add, carry chain,
// busy protection, mid-op reset, back-to-back, exhaustive sweep.
module tb_serial_adder;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a, b;
    logic         c;
    logic [W-1:0] s;
    logic         co, busy, done;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;   // done pulses seen by the monitor
    int exp_done = 0;   // done pulses the bench expects

    serial_adder #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .a    (a),
        .b    (b),
        .c    (c),
        .s    (s),
        .co   (co),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    // done spans one full cycle, so it is counted once at the falling edge.
    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete operation: accept, check busy each cycle, bounded wait
    // for done, check latency/result, then check done drops.
    task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic tc, input logic [W:0] exp);
        int lat;
        a = ta; b = tb_; c = tc; start = 1'b1;
        tick();                       // E0
        start = 1'b0;
        a = ~ta; b = ~tb_; c = ~tc;   // operands must not matter after E0
        lat = 0;
        chk({tag, "_busy0"}, 32'(busy), 32'd1);
        while (done !== 1'b1 && lat < 10) begin
            tick();
            lat++;
            if (done !== 1'b1) chk({tag, "_busy"}, 32'(busy), 32'd1);
        end
        chk({tag, "_lat"}, 32'(lat), 32'(W));
        chk({tag, "_sum"}, 32'({co, s}), 32'(exp));
        chk({tag, "_busyend"}, 32'(busy), 32'd0);
        exp_done++;
        tick();
        chk({tag, "_donefall"}, 32'(done), 32'd0);
        chk({tag, "_hold"}, 32'({co, s}), 32'(exp));
    endtask

    initial begin
        logic [W:0] bb_exp [3];
        logic [W-1:0] bb_a [3];
        logic [W-1:0] bb_b [3];
        int timeout;

        // ---- reset ----
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; c = 1'b0;
        #3;
        chk("rst_s", 32'(s), 32'd0);
        chk("rst_co", 32'(co), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick();
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'(done), 32'd0);

        // ---- basic add and carry chain (hand-computed) ----
        run_op("basic", 4'd3, 4'd5, 1'b0, 5'b0_1000);   // 8
        run_op("carry1", 4'd15, 4'd1, 1'b0, 5'b1_0000); // 16
        run_op("carry2", 4'd15, 4'd15, 1'b1, 5'b1_1111); // 31
        run_op("cin", 4'd0, 4'd0, 1'b1, 5'b0_0001);     // 1

        // ---- busy protection: second start ignored ----
        a = 4'd2; b = 4'd2; c = 1'b0; start = 1'b1;
        tick();                       // E0
        start = 1'b0;
        tick(); tick();               // E1, E2
        a = 4'd9; b = 4'd9; start = 1'b1;
        tick();                       // E3 (ignored)
        start = 1'b0;
        chk("bp_done_early", 32'(done), 32'd0);
        tick();                       // E4
        exp_done++;
        chk("bp_done", 32'(done), 32'd1);
        chk("bp_sum", 32'({co, s}), 32'd4);
        repeat (8) tick();
        chk("bp_one_done", 32'(done_cnt), 32'(exp_done));
        chk("bp_busy", 32'(busy), 32'd0);
        chk("bp_hold", 32'({co, s}), 32'd4);

        // ---- reset mid-operation ----
        a = 4'd7; b = 4'd7; c = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        rst_n = 1'b0;
        #1;
        chk("mr_s", 32'(s), 32'd0);
        chk("mr_co", 32'(co), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_done", 32'(done), 32'd0);
        tick();
        rst_n = 1'b1;
        repeat (8) tick();
        chk("mr_no_done", 32'(done_cnt), 32'(exp_done));
        chk("mr_s_after", 32'({co, s}), 32'd0);
        run_op("mr_restart", 4'd7, 4'd7, 1'b0, 5'd14);

        // ---- back-to-back with start held high ----
        bb_a[0] = 4'd1;  bb_b[0] = 4'd2;  bb_exp[0] = 5'd3;
        bb_a[1] = 4'd12; bb_b[1] = 4'd9;  bb_exp[1] = 5'd21;
        bb_a[2] = 4'd8;  bb_b[2] = 4'd8;  bb_exp[2] = 5'd16;
        c = 1'b0;
        a = bb_a[0]; b = bb_b[0]; start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();                   // E0 of operation k
            if (k < 2) begin
                a = bb_a[k+1]; b = bb_b[k+1];
            end else begin
                a = 4'd0; b = 4'd0; start = 1'b0;
            end
            tick(); tick(); tick();
            chk("bb_done_early", 32'(done), 32'd0);
            tick();                   // E4
            exp_done++;
            chk("bb_done", 32'(done), 32'd1);
            chk("bb_sum", 32'({co, s}), 32'(bb_exp[k]));
        end
        tick();
        chk("bb_donefall", 32'(done), 32'd0);
        chk("bb_idle", 32'(busy), 32'd0);
        chk("bb_count", 32'(done_cnt), 32'(exp_done));

        // ---- exhaustive sweep with scoreboard ----
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    a = W'(ia); b = W'(ib); c = ic[0]; start = 1'b1;
                    tick();
                    start = 1'b0;
                    timeout = 0;
                    while (done !== 1'b1 && timeout < 10) begin
                        tick();
                        timeout++;
                    end
                    exp_done++;
                    if (timeout != W) chk("sw_lat", 32'(timeout), 32'(W));
                    chk("sw_sum", 32'({co, s}), 32'(ia + ib + ic));
                end
            end
        end
        tick(); tick();
        chk("sw_done_count", 32'(done_cnt), 32'(exp_done));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
